// File: rtl/fifo_push_arbiter_pkg.sv
// Shared defaults for the arbiter and its FIFO, plus a clog2 helper usable in
// parameter expressions.
package fifo_push_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int MEM_DEPTH_DEF  = 8;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO. pop_data is registered and updates on the edge that pops.
// A push is dropped when full, and a pop is ignored when empty.
module fifo
  import fifo_push_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = MEM_DEPTH_DEF,
  localparam int AW        = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW        = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop) begin
        rd_ptr   <= bump(rd_ptr);
        pop_data <= mem[rd_ptr];
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational rotate-priority picker that finds the first set bit of elig,
// scanning from ptr+1 upward with wrap-around.
module fifo_push_arbiter_rr_pick
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    cand       = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (elig[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        winner_idx   = cand;
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter for a shared FIFO push port, with registered push/data (one cycle after the decision).
// Local occupancy counts any push in flight, so a push can never overflow the FIFO.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int NUM_REQ    = 4,
  localparam int OCC_W     = clog2(MEM_DEPTH + 1),
  localparam int IDX_W     = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_pop,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [OCC_W-1:0]              occupancy,
  output logic                          overflow_err
);

  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(MEM_DEPTH);

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      ptr;
  logic                  win_any;
  logic [OCC_W:0]        occ_sum;
  logic                  space;
  logic                  take;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The producer being granted this cycle still holds its old word, so it is masked.
  assign elig = req & ~grant;

  // Count the push in flight, but not a pop in the same cycle.
  assign occ_sum = {1'b0, occupancy} + (OCC_W + 1)'(fifo_push);
  assign space   = (occ_sum < DEPTH_L);
  assign take    = enable & space & win_any;
  assign pop_ok  = fifo_pop && (occupancy != '0);

  fifo_push_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .elig      (elig),
    .ptr       (ptr),
    .winner    (win_onehot),
    .winner_idx(win_idx),
    .any       (win_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      fifo_push <= 1'b0;
      fifo_data <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
    end else if (take) begin
      grant     <= win_onehot;
      fifo_push <= 1'b1;
      fifo_data <= words[win_idx];
      ptr       <= win_idx;
    end else begin
      grant     <= '0;
      fifo_push <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(fifo_push) - OCC_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_err <= 1'b0;
    end else if (fifo_push && fifo_full) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter driving a real FIFO, using vector tables
// plus hand sequences for full/near-full, enable and reset corners.
module tb_fifo_push_arbiter;
  import fifo_push_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int NR = 4;
  localparam int OW = 4;

  logic           clk;
  logic           reset;
  logic           enable;
  logic           fifo_pop;
  logic           force_full;
  logic [NR-1:0]  req;
  logic [NR-1:0]  grant;
  logic [NR*DW-1:0] req_data;
  logic           full_real;
  logic           full_to_dut;
  logic           empty;
  logic           fifo_push;
  logic           overflow_err;
  logic [DW-1:0]  fifo_data;
  logic [DW-1:0]  dout;
  logic [OW-1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        do_rst;
    logic        en;
    logic [3:0]  req;
    logic        pop;
    logic [63:0] data;
    logic [3:0]  g;
    logic        p;
    logic [15:0] d;
    logic [3:0]  o;
  } vec_t;

  vec_t vecs [13];

  assign full_to_dut = full_real | force_full;

  fifo_push_arbiter #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .NUM_REQ(NR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .req_data    (req_data),
    .fifo_pop    (fifo_pop),
    .fifo_full   (full_to_dut),
    .grant       (grant),
    .fifo_push   (fifo_push),
    .fifo_data   (fifo_data),
    .occupancy   (occupancy),
    .overflow_err(overflow_err)
  );

  fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_data),
    .pop      (fifo_pop),
    .pop_data (dout),
    .full     (full_real),
    .empty    (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("occ_vs_full", 64'(occupancy == 4'd8), 64'(full_real));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_push", 64'(fifo_push), 64'd0);
    chk("rst_data", 64'(fifo_data), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_err", 64'(overflow_err), 64'd0);
    reset = 1'b1;
  endtask

  task automatic apply_vec(input int i);
    if (vecs[i].do_rst) do_reset();
    enable   = vecs[i].en;
    req      = vecs[i].req;
    fifo_pop = vecs[i].pop;
    req_data = vecs[i].data;
    tick();
    chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vecs[i].g));
    chk($sformatf("v%0d_push", i), 64'(fifo_push), 64'(vecs[i].p));
    chk($sformatf("v%0d_data", i), 64'(fifo_data), 64'(vecs[i].d));
    chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(vecs[i].o));
  endtask

  localparam logic [63:0] W8    = 64'h0000_0000_0000_0008;
  localparam logic [63:0] W1357 = 64'h0007_0005_0003_0001;

  initial begin
    // Single producer: grant, masked re-request, then a pop that empties it.
    vecs[0]  = '{1'b1, 1'b1, 4'b0001, 1'b0, W8,    4'b0001, 1'b1, 16'd8, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 4'b0001, 1'b0, W8,    4'b0000, 1'b0, 16'd8, 4'd1};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, 1'b1, W8,    4'b0000, 1'b0, 16'd8, 4'd0};
    // Four producers held: rotate 0..3 twice, then stop at full.
    vecs[3]  = '{1'b1, 1'b1, 4'b1111, 1'b0, W1357, 4'b0001, 1'b1, 16'd1, 4'd0};
    vecs[4]  = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b0010, 1'b1, 16'd3, 4'd1};
    vecs[5]  = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b0100, 1'b1, 16'd5, 4'd2};
    vecs[6]  = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b1000, 1'b1, 16'd7, 4'd3};
    vecs[7]  = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b0001, 1'b1, 16'd1, 4'd4};
    vecs[8]  = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b0010, 1'b1, 16'd3, 4'd5};
    vecs[9]  = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b0100, 1'b1, 16'd5, 4'd6};
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b1000, 1'b1, 16'd7, 4'd7};
    vecs[11] = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b0000, 1'b0, 16'd7, 4'd8};
    vecs[12] = '{1'b0, 1'b1, 4'b1111, 1'b0, W1357, 4'b0000, 1'b0, 16'd7, 4'd8};

    reset = 1'b0; enable = 1'b0; req = '0; req_data = '0;
    fifo_pop = 1'b0; force_full = 1'b0;
    tick();

    for (int i = 0; i <= 2; i++) apply_vec(i);
    chk("t1_dout", 64'(dout), 64'd8);
    chk("t1_empty", 64'(empty), 64'd1);

    for (int i = 3; i <= 12; i++) apply_vec(i);
    chk("t2_full", 64'(full_real), 64'd1);
    chk("t2_err", 64'(overflow_err), 64'd0);

    // One pop from full frees exactly one slot, taken on the following decision.
    req = 4'b0100; req_data = 64'h0000_0022_0000_0000; fifo_pop = 1'b1;
    tick();
    chk("t3a_grant", 64'(grant), 64'd0);
    chk("t3a_occ", 64'(occupancy), 64'd7);
    chk("t3a_dout", 64'(dout), 64'd1);
    fifo_pop = 1'b0;
    tick();
    chk("t3b_grant", 64'(grant), 64'b0100);
    chk("t3b_data", 64'(fifo_data), 64'h22);
    chk("t3b_occ", 64'(occupancy), 64'd7);
    req = 4'b0000;
    tick();
    chk("t3c_grant", 64'(grant), 64'd0);
    chk("t3c_occ", 64'(occupancy), 64'd8);
    chk("t3c_err", 64'(overflow_err), 64'd0);

    // Near full with a push in flight: same-cycle pop must not be credited.
    req = 4'b0011; req_data = 64'h0000_0000_0041_0040; fifo_pop = 1'b1;
    tick();
    chk("t4a_grant", 64'(grant), 64'd0);
    chk("t4a_occ", 64'(occupancy), 64'd7);
    fifo_pop = 1'b0;
    tick();
    chk("t4b_grant", 64'(grant), 64'b0001);
    chk("t4b_data", 64'(fifo_data), 64'h40);
    req = 4'b0010; fifo_pop = 1'b1;
    tick();
    chk("t4c_grant", 64'(grant), 64'd0);
    chk("t4c_push", 64'(fifo_push), 64'd0);
    chk("t4c_occ", 64'(occupancy), 64'd7);
    fifo_pop = 1'b0;
    tick();
    chk("t4d_grant", 64'(grant), 64'b0010);
    chk("t4d_data", 64'(fifo_data), 64'h41);
    chk("t4d_occ", 64'(occupancy), 64'd7);
    req = 4'b0000;
    tick();
    chk("t4e_occ", 64'(occupancy), 64'd8);

    // enable dropped mid-burst, then resumed.
    do_reset();
    enable = 1'b1; req = 4'b1111; req_data = W1357; fifo_pop = 1'b0;
    tick();
    chk("t5_e1_grant", 64'(grant), 64'b0001);
    tick();
    chk("t5_e2_grant", 64'(grant), 64'b0010);
    chk("t5_e2_push", 64'(fifo_push), 64'd1);
    enable = 1'b0;
    tick();
    chk("t5_e3_grant", 64'(grant), 64'd0);
    chk("t5_e3_push", 64'(fifo_push), 64'd0);
    chk("t5_e3_occ", 64'(occupancy), 64'd2);
    chk("t5_e3_data", 64'(fifo_data), 64'd3);
    tick();
    chk("t5_e4_grant", 64'(grant), 64'd0);
    enable = 1'b1;
    tick();
    chk("t5_e5_grant", 64'(grant), 64'b0100);
    chk("t5_e5_data", 64'(fifo_data), 64'd5);
    tick();
    chk("t5_e6_grant", 64'(grant), 64'b1000);
    chk("t5_e6_occ", 64'(occupancy), 64'd3);
    tick();
    tick();
    chk("t6_pre_grant", 64'(grant), 64'b0010);
    chk("t6_pre_occ", 64'(occupancy), 64'd5);

    // Asynchronous reset in the middle of a cycle with a push in flight.
    #2;
    reset = 1'b0;
    #1;
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_push", 64'(fifo_push), 64'd0);
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_data", 64'(fifo_data), 64'd0);
    chk("t6_err", 64'(overflow_err), 64'd0);
    reset = 1'b1;

    // Sticky error, plus a pop at empty that must be ignored even with a push.
    req = 4'b0001; req_data = 64'h0000_0000_0000_0009; force_full = 1'b1;
    tick();
    chk("t7_e1_push", 64'(fifo_push), 64'd1);
    chk("t7_e1_err", 64'(overflow_err), 64'd0);
    req = 4'b0000; fifo_pop = 1'b1;
    tick();
    chk("t7_e2_err", 64'(overflow_err), 64'd1);
    chk("t7_e2_occ", 64'(occupancy), 64'd1);
    force_full = 1'b0; fifo_pop = 1'b0;
    tick();
    chk("t7_e3_err", 64'(overflow_err), 64'd1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
